hilo_muldiv: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers, sitting directly downstream of the register file. It takes the two read-port words RD1/RD2 as operands, computes MULT/MULTU/DIV/DIVU over 32 iterations, and holds the result in HI/LO. The HI/LO values feed back to the write-back mux so MFHI/MFLO can reach the register file write port. While it is busy, `busy` stalls instruction fetch.

---
 rtl/hilo_muldiv.sv | 152 +++++++++++++++
 tb/tb_hilo_muldiv.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// Iterative 32-cycle multiply/divide unit holding its results in the HI/LO registers.
// One shared 2*DATA_W work register serves as the product accumulator or as {remainder, quotient}.
module hilo_muldiv #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] src_a_i,
  input  logic [DATA_W-1:0] src_b_i,
  input  logic              hi_we_i,
  input  logic              lo_we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                is_div_q, is_div_d;
  logic                q_neg_q, q_neg_d;
  logic                r_neg_q, r_neg_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;

  logic                is_signed, a_neg, b_neg;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_next;
  logic [DATA_W:0]     div_trial, div_diff;
  logic [2*DATA_W-1:0] div_next;
  logic [2*DATA_W-1:0] step;
  logic [2*DATA_W-1:0] prod_res;
  logic [DATA_W-1:0]   quo_res, rem_res;

  // Magnitudes of the incoming operands, used only on the launch edge.
  always_comb begin
    is_signed = ~op_i[0];
    a_neg     = is_signed & src_a_i[DATA_W-1];
    b_neg     = is_signed & src_b_i[DATA_W-1];
    a_mag     = a_neg ? -src_a_i : src_a_i;
    b_mag     = b_neg ? -src_b_i : src_b_i;
  end

  // One iteration. Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[DATA_W-1:1]};
    div_trial = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    div_diff  = div_trial - {1'b0, opnd_q};
    div_next  = div_diff[DATA_W] ? {div_trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0}
                                 : {div_diff[DATA_W-1:0],  acc_q[DATA_W-2:0], 1'b1};
    step      = is_div_q ? div_next : mul_next;
    prod_res  = q_neg_q ? -step : step;
    quo_res   = q_neg_q ? -step[DATA_W-1:0] : step[DATA_W-1:0];
    rem_res   = r_neg_q ? -step[2*DATA_W-1:DATA_W] : step[2*DATA_W-1:DATA_W];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (hi_we_i) hi_d = wdata_i;
        if (lo_we_i) lo_d = wdata_i;
        if (start_i) begin
          state_d  = S_CALC;
          cnt_d    = '0;
          is_div_d = op_i[1];
          q_neg_d  = a_neg ^ b_neg;
          r_neg_d  = a_neg;
          opnd_d   = op_i[1] ? b_mag : a_mag;
          acc_d    = op_i[1] ? {{DATA_W{1'b0}}, a_mag} : {{DATA_W{1'b0}}, b_mag};
        end
      end
      S_CALC: begin
        acc_d = step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = S_FIN;
          // The last iteration and the sign fix-up commit together on this edge.
          if (is_div_q) begin
            hi_d = rem_res;
            lo_d = quo_res;
          end else begin
            hi_d = prod_res[2*DATA_W-1:DATA_W];
            lo_d = prod_res[DATA_W-1:0];
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_FIN);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: vector table of operations plus busy-guard,
// same-edge MT/start and asynchronous-reset sequences.
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_total = 0;
  int n_pass  = 0;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  hilo_muldiv #(.DATA_W(32)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .op_i    (op),
    .src_a_i (src_a),
    .src_b_i (src_b),
    .hi_we_i (hi_we),
    .lo_we_i (lo_we),
    .wdata_i (wdata),
    .busy_o  (busy),
    .done_o  (done),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Launch at a negedge (cycle 0), check busy/done each cycle 1..34 and HI/LO at cycle 33.
  // mt_launch: also MTHI 0x55 on the launch edge. poke>0: in that CALC cycle, try a new
  // start with different operands plus MTHI/MTLO, all of which must be ignored.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input string tag,
                        input bit mt_launch, input int poke);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    if (mt_launch) begin hi_we = 1'b1; wdata = 32'h55; end
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        src_a = 32'hA5A5_0F0F; src_b = 32'h0000_0003; op = ~o;
        if (mt_launch) check($sformatf("%s mt_on_launch hi", tag), hi, 32'h55);
      end
      if (c == poke) begin
        start = 1'b1; op = OP_DIVU; src_a = 32'h1111; src_b = 32'h2;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD;
      end else if (c == poke + 1) begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      check($sformatf("%s busy c%0d", tag, c), {31'b0, busy}, {31'b0, (c <= 33)});
      check($sformatf("%s done c%0d", tag, c), {31'b0, done}, {31'b0, (c == 33)});
      if (c == 33) begin
        check($sformatf("%s hi", tag), hi, eh);
        check($sformatf("%s lo", tag), lo, el);
        $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h (exp %h/%h)", tag, o, a, b, hi, lo, eh, el);
      end
    end
  endtask

  initial begin
    vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{OP_DIVU,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF};
    vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{OP_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vecs[6]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[7]  = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8]  = '{OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
    vecs[9]  = '{OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'h0000_0001};
    vecs[10] = '{OP_MULT,  32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
             $sformatf("vec%0d", i), 1'b0, 0);

    // Busy guards: start and MT writes during CALC are dropped.
    run_op(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, "guard", 1'b0, 5);
    hi_we = 1'b1; wdata = 32'hDEAD;
    @(negedge clk);
    hi_we = 1'b0;
    check("idle mthi hi", hi, 32'hDEAD);
    check("idle mthi lo", lo, 32'd42);
    lo_we = 1'b1; wdata = 32'hBEEF;
    @(negedge clk);
    lo_we = 1'b0;
    check("idle mtlo lo", lo, 32'hBEEF);
    check("idle mtlo hi", hi, 32'hDEAD);
    check("idle mt busy", {31'b0, busy}, 32'd0);
    $display("idle MT writes -> hi=%h lo=%h", hi, lo);

    // Same edge: MTHI commits, then the launched op overwrites HI/LO.
    run_op(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, "same_edge", 1'b1, 0);

    // Asynchronous reset in cycle 10 of a DIV.
    @(negedge clk);
    start = 1'b1; op = OP_DIV; src_a = 32'hFFFF_FFF9; src_b = 32'd2;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1 rst = 1'b1;
    #1;
    check("midrst busy", {31'b0, busy}, 32'd0);
    check("midrst done", {31'b0, done}, 32'd0);
    check("midrst hi", hi, 32'd0);
    check("midrst lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int n_done = 0;
      int n_busy = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (done) n_done++;
        if (busy) n_busy++;
      end
      check("midrst no done pulses", n_done, 0);
      check("midrst no busy cycles", n_busy, 0);
      check("midrst hi held", hi, 32'd0);
    end
    $display("reset mid-DIV -> busy=%0d hi=%h lo=%h", busy, hi, lo);
    run_op(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, "post_rst", 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
